// File: rtl/irq_encoder_8_to_3_if.sv
// Handshake/status bundle between the interrupt encoder and the CPU control unit.
// The master side drives requests, mask writes and ack/eoi; the slave side is the encoder.
interface irq_encoder_8_to_3_if;
   logic [7:0] req;
   logic       E;
   logic       mask_we;
   logic [7:0] mask_in;
   logic       ack;
   logic       eoi;
   logic       valid;
   logic [2:0] vec;
   logic       in_service;
   logic [7:0] pending;
   logic [7:0] mask;

   modport master (
      output req, E, mask_we, mask_in, ack, eoi,
      input  valid, vec, in_service, pending, mask
   );

   modport slave (
      input  req, E, mask_we, mask_in, ack, eoi,
      output valid, vec, in_service, pending, mask
   );
endinterface

// File: rtl/irq_encoder_8_to_3.sv
// 8-line interrupt encoder: latches requests into a pending register and presents the
// highest-priority unmasked one as a 3-bit vector via a valid/ack/eoi handshake.
module irq_encoder_8_to_3 #(
   parameter bit         EDGE     = 1'b1,
   parameter logic [7:0] RST_MASK = 8'hFF
) (
   input logic               clk,
   input logic               rst,
   irq_encoder_8_to_3_if.slave bus
);

   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

   state_t     state;
   logic [7:0] req_d;
   logic [7:0] pending_r;
   logic [7:0] mask_r;
   logic [2:0] vec_r;
   logic       valid_r;
   logic       in_service_r;

   logic [7:0] set;
   logic [7:0] clr;
   logic [7:0] eligible;
   logic [2:0] vec_next;

   always_comb begin
      set = EDGE ? (bus.req & ~req_d) : bus.req;
      clr = '0;
      if (state == REQ && bus.ack)
         clr[vec_r] = 1'b1;
      eligible = pending_r & ~mask_r;
      vec_next = '0;
      // Ascending scan so the highest set bit is the last one written.
      for (int unsigned i = 0; i < 8; i++)
         if (eligible[i])
            vec_next = 3'(i);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         req_d        <= '0;
         pending_r    <= '0;
         mask_r       <= RST_MASK;
         vec_r        <= '0;
         valid_r      <= 1'b0;
         in_service_r <= 1'b0;
      end else begin
         req_d     <= bus.req;
         pending_r <= set | (pending_r & ~clr);
         if (bus.mask_we)
            mask_r <= bus.mask_in;
         case (state)
            IDLE: begin
               if (bus.E && eligible != '0) begin
                  vec_r   <= vec_next;
                  valid_r <= 1'b1;
                  state   <= REQ;
               end
            end
            REQ: begin
               if (bus.ack) begin
                  valid_r      <= 1'b0;
                  in_service_r <= 1'b1;
                  state        <= SERVICE;
               end
            end
            SERVICE: begin
               if (bus.eoi) begin
                  in_service_r <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: begin
               state        <= IDLE;
               valid_r      <= 1'b0;
               in_service_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.valid      = valid_r;
   assign bus.vec        = vec_r;
   assign bus.in_service = in_service_r;
   assign bus.pending    = pending_r;
   assign bus.mask       = mask_r;

endmodule

// File: tb/tb_irq_encoder_8_to_3.sv
// Directed bench for irq_encoder_8_to_3: an edge-capture instance and a level-capture instance.
module tb_irq_encoder_8_to_3;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   ncmp = 0;
   int   nerr = 0;

   always #5 clk = ~clk;

   irq_encoder_8_to_3_if bus ();
   irq_encoder_8_to_3_if lbus ();

   irq_encoder_8_to_3 #(.EDGE(1'b1), .RST_MASK(8'hFF)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   irq_encoder_8_to_3 #(.EDGE(1'b0), .RST_MASK(8'hFF)) dut_lvl (
      .clk (clk),
      .rst (rst),
      .bus (lbus.slave)
   );

   // One active edge, then settle so outputs are sampled away from the edge.
   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic write_mask(input logic [7:0] m);
      bus.mask_we = 1'b1; bus.mask_in = m;
      step();
      bus.mask_we = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      ncmp++; if (bus.valid !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b want 0", bus.valid); end
      ncmp++; if (bus.vec !== 3'd0) begin nerr++; $display("FAIL reset_vec: got %0d want 0", bus.vec); end
      ncmp++; if (bus.in_service !== 1'b0) begin nerr++; $display("FAIL reset_insvc: got %b want 0", bus.in_service); end
      ncmp++; if (bus.pending !== 8'h00) begin nerr++; $display("FAIL reset_pending: got %h want 00", bus.pending); end
      ncmp++; if (bus.mask !== 8'hFF) begin nerr++; $display("FAIL reset_mask: got %h want ff", bus.mask); end
      ncmp++; if (lbus.mask !== 8'hFF) begin nerr++; $display("FAIL reset_lvl_mask: got %h want ff", lbus.mask); end
   endtask

   task automatic test_basic();
      write_mask(8'h00);
      ncmp++; if (bus.mask !== 8'h00) begin nerr++; $display("FAIL basic_mask: got %h want 00", bus.mask); end
      bus.req = 8'h08;
      step();
      bus.req = 8'h00;
      ncmp++; if (bus.pending !== 8'h08) begin nerr++; $display("FAIL basic_pending: got %h want 08", bus.pending); end
      ncmp++; if (bus.valid !== 1'b0) begin nerr++; $display("FAIL basic_not_yet_valid: got %b want 0", bus.valid); end
      step();
      ncmp++; if (bus.valid !== 1'b1) begin nerr++; $display("FAIL basic_valid: got %b want 1", bus.valid); end
      ncmp++; if (bus.vec !== 3'd3) begin nerr++; $display("FAIL basic_vec: got %0d want 3", bus.vec); end
      bus.ack = 1'b1;
      step();
      bus.ack = 1'b0;
      ncmp++; if (bus.valid !== 1'b0) begin nerr++; $display("FAIL basic_ack_valid: got %b want 0", bus.valid); end
      ncmp++; if (bus.in_service !== 1'b1) begin nerr++; $display("FAIL basic_ack_insvc: got %b want 1", bus.in_service); end
      ncmp++; if (bus.pending !== 8'h00) begin nerr++; $display("FAIL basic_ack_pending: got %h want 00", bus.pending); end
      bus.eoi = 1'b1;
      step();
      bus.eoi = 1'b0;
      ncmp++; if (bus.in_service !== 1'b0) begin nerr++; $display("FAIL basic_eoi_insvc: got %b want 0", bus.in_service); end
   endtask

   task automatic test_priority();
      bus.req = 8'h82;
      step();
      bus.req = 8'h00;
      step();
      ncmp++; if (bus.vec !== 3'd7 || bus.valid !== 1'b1) begin nerr++; $display("FAIL prio_vec7: got valid=%b vec=%0d want 1/7", bus.valid, bus.vec); end
      bus.ack = 1'b1;
      step();
      bus.ack = 1'b0;
      ncmp++; if (bus.pending !== 8'h02) begin nerr++; $display("FAIL prio_pending: got %h want 02", bus.pending); end
      bus.eoi = 1'b1;
      step();
      bus.eoi = 1'b0;
      ncmp++; if (bus.valid !== 1'b0) begin nerr++; $display("FAIL prio_eoi_edge_valid: got %b want 0", bus.valid); end
      step();
      ncmp++; if (bus.vec !== 3'd1 || bus.valid !== 1'b1) begin nerr++; $display("FAIL prio_vec1: got valid=%b vec=%0d want 1/1", bus.valid, bus.vec); end
      bus.ack = 1'b1; step(); bus.ack = 1'b0;
      bus.eoi = 1'b1; step(); bus.eoi = 1'b0;
   endtask

   task automatic test_mask();
      write_mask(8'h80);
      bus.req = 8'h81;
      step();
      bus.req = 8'h00;
      step();
      ncmp++; if (bus.vec !== 3'd0 || bus.valid !== 1'b1) begin nerr++; $display("FAIL mask_vec0: got valid=%b vec=%0d want 1/0", bus.valid, bus.vec); end
      ncmp++; if (bus.pending !== 8'h81) begin nerr++; $display("FAIL mask_pending: got %h want 81", bus.pending); end
      bus.ack = 1'b1; step(); bus.ack = 1'b0;
      write_mask(8'h00);
      ncmp++; if (bus.mask !== 8'h00 || bus.in_service !== 1'b1) begin nerr++; $display("FAIL mask_write_svc: got mask=%h insvc=%b want 00/1", bus.mask, bus.in_service); end
      bus.eoi = 1'b1; step(); bus.eoi = 1'b0;
      step();
      ncmp++; if (bus.vec !== 3'd7 || bus.valid !== 1'b1) begin nerr++; $display("FAIL mask_vec7: got valid=%b vec=%0d want 1/7", bus.valid, bus.vec); end
      bus.ack = 1'b1; step(); bus.ack = 1'b0;
      bus.eoi = 1'b1; step(); bus.eoi = 1'b0;
   endtask

   task automatic test_no_preempt();
      bus.req = 8'h04;
      step();
      bus.req = 8'h00;
      step();
      ncmp++; if (bus.vec !== 3'd2 || bus.valid !== 1'b1) begin nerr++; $display("FAIL nopre_vec2: got valid=%b vec=%0d want 1/2", bus.valid, bus.vec); end
      bus.req = 8'h40;
      step();
      bus.req = 8'h00;
      ncmp++; if (bus.pending !== 8'h44) begin nerr++; $display("FAIL nopre_pending: got %h want 44", bus.pending); end
      step();
      ncmp++; if (bus.vec !== 3'd2 || bus.valid !== 1'b1) begin nerr++; $display("FAIL nopre_frozen: got valid=%b vec=%0d want 1/2", bus.valid, bus.vec); end
      bus.ack = 1'b1; step(); bus.ack = 1'b0;
      bus.eoi = 1'b1; step(); bus.eoi = 1'b0;
      step();
      ncmp++; if (bus.vec !== 3'd6 || bus.valid !== 1'b1) begin nerr++; $display("FAIL nopre_vec6: got valid=%b vec=%0d want 1/6", bus.valid, bus.vec); end
      bus.ack = 1'b1; step(); bus.ack = 1'b0;
      bus.eoi = 1'b1; step(); bus.eoi = 1'b0;
   endtask

   task automatic test_enable();
      bus.E = 1'b0;
      bus.req = 8'h10;
      step();
      bus.req = 8'h00;
      step(2);
      ncmp++; if (bus.valid !== 1'b0) begin nerr++; $display("FAIL en_gated: got %b want 0", bus.valid); end
      ncmp++; if (bus.pending !== 8'h10) begin nerr++; $display("FAIL en_pending: got %h want 10", bus.pending); end
      bus.E = 1'b1;
      step();
      ncmp++; if (bus.vec !== 3'd4 || bus.valid !== 1'b1) begin nerr++; $display("FAIL en_vec4: got valid=%b vec=%0d want 1/4", bus.valid, bus.vec); end
      bus.ack = 1'b1; step(); bus.ack = 1'b0;
      bus.eoi = 1'b1; step(); bus.eoi = 1'b0;
   endtask

   task automatic test_set_wins();
      bus.req = 8'h20;
      step();
      bus.req = 8'h00;
      step();
      ncmp++; if (bus.vec !== 3'd5 || bus.valid !== 1'b1) begin nerr++; $display("FAIL setwin_vec5: got valid=%b vec=%0d want 1/5", bus.valid, bus.vec); end
      bus.req = 8'h20; bus.ack = 1'b1;
      step();
      bus.req = 8'h00; bus.ack = 1'b0;
      ncmp++; if (bus.pending !== 8'h20 || bus.in_service !== 1'b1) begin nerr++; $display("FAIL setwin_pending: got pend=%h insvc=%b want 20/1", bus.pending, bus.in_service); end
      bus.eoi = 1'b1; step(); bus.eoi = 1'b0;
      step();
      ncmp++; if (bus.vec !== 3'd5 || bus.valid !== 1'b1) begin nerr++; $display("FAIL setwin_repres: got valid=%b vec=%0d want 1/5", bus.valid, bus.vec); end
      bus.ack = 1'b1; step(); bus.ack = 1'b0;
      ncmp++; if (bus.pending !== 8'h00) begin nerr++; $display("FAIL setwin_cleared: got %h want 00", bus.pending); end
      bus.eoi = 1'b1; step(); bus.eoi = 1'b0;
   endtask

   task automatic test_level();
      lbus.mask_we = 1'b1; lbus.mask_in = 8'h00;
      step();
      lbus.mask_we = 1'b0;
      lbus.req = 8'h20;
      step();
      ncmp++; if (lbus.pending !== 8'h20) begin nerr++; $display("FAIL lvl_pending: got %h want 20", lbus.pending); end
      step();
      ncmp++; if (lbus.vec !== 3'd5 || lbus.valid !== 1'b1) begin nerr++; $display("FAIL lvl_vec5: got valid=%b vec=%0d want 1/5", lbus.valid, lbus.vec); end
      lbus.ack = 1'b1;
      step();
      lbus.ack = 1'b0;
      ncmp++; if (lbus.pending !== 8'h20 || lbus.in_service !== 1'b1) begin nerr++; $display("FAIL lvl_reset_bit: got pend=%h insvc=%b want 20/1", lbus.pending, lbus.in_service); end
      lbus.req = 8'h00;
      lbus.eoi = 1'b1; step(); lbus.eoi = 1'b0;
      step();
      ncmp++; if (lbus.vec !== 3'd5 || lbus.valid !== 1'b1) begin nerr++; $display("FAIL lvl_repres: got valid=%b vec=%0d want 1/5", lbus.valid, lbus.vec); end
   endtask

   task automatic test_reset_mid();
      bus.req = 8'h01; step(); bus.req = 8'h00; step();
      ncmp++; if (bus.valid !== 1'b1) begin nerr++; $display("FAIL rstreq_pre: got %b want 1", bus.valid); end
      rst = 1'b1; step(); rst = 1'b0;
      ncmp++; if (bus.valid !== 1'b0 || bus.in_service !== 1'b0 || bus.pending !== 8'h00 || bus.mask !== 8'hFF)
         begin nerr++; $display("FAIL rst_in_req: got v=%b s=%b p=%h m=%h want 0/0/00/ff", bus.valid, bus.in_service, bus.pending, bus.mask); end
      write_mask(8'h00);
      bus.req = 8'h02; step(); bus.req = 8'h00; step();
      bus.ack = 1'b1; step(); bus.ack = 1'b0;
      ncmp++; if (bus.in_service !== 1'b1) begin nerr++; $display("FAIL rstsvc_pre: got %b want 1", bus.in_service); end
      // Hold req[3] high across reset; req_d clears, so it counts as one fresh rise.
      bus.req = 8'h08;
      rst = 1'b1; step(); rst = 1'b0;
      ncmp++; if (bus.valid !== 1'b0 || bus.in_service !== 1'b0 || bus.pending !== 8'h00 || bus.mask !== 8'hFF)
         begin nerr++; $display("FAIL rst_in_svc: got v=%b s=%b p=%h m=%h want 0/0/00/ff", bus.valid, bus.in_service, bus.pending, bus.mask); end
      write_mask(8'h00);
      ncmp++; if (bus.pending !== 8'h08) begin nerr++; $display("FAIL held_first: got %h want 08", bus.pending); end
      step();
      bus.ack = 1'b1; step(); bus.ack = 1'b0;
      bus.eoi = 1'b1; step(); bus.eoi = 1'b0;
      step(3);
      ncmp++; if (bus.pending !== 8'h00 || bus.valid !== 1'b0) begin nerr++; $display("FAIL held_no_recapture: got p=%h v=%b want 00/0", bus.pending, bus.valid); end
      bus.req = 8'h00; step();
      bus.req = 8'h08; step();
      bus.req = 8'h00;
      ncmp++; if (bus.pending !== 8'h08) begin nerr++; $display("FAIL held_rerise: got %h want 08", bus.pending); end
      step();
      ncmp++; if (bus.vec !== 3'd3 || bus.valid !== 1'b1) begin nerr++; $display("FAIL held_vec3: got valid=%b vec=%0d want 1/3", bus.valid, bus.vec); end
   endtask

   initial begin
      bus.req = '0; bus.E = 1'b1; bus.mask_we = 1'b0; bus.mask_in = '0; bus.ack = 1'b0; bus.eoi = 1'b0;
      lbus.req = '0; lbus.E = 1'b1; lbus.mask_we = 1'b0; lbus.mask_in = '0; lbus.ack = 1'b0; lbus.eoi = 1'b0;
      #2;
      test_reset();
      test_basic();
      test_priority();
      test_mask();
      test_no_preempt();
      test_enable();
      test_set_wins();
      test_level();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
